wb_buffer: RTL and testbench

- Write-back buffer that sits directly downstream of the 1 KB cache's dirty-eviction port.
- Accepts 64-bit victim entries {data, address} from the cache.
- Queues them in order and drains them to main memory over a valid/ready write handshake.
- Snoops cache miss reads (cm_ReadAddr) so a read that targets a still-queued victim gets the buffered (newest) data, not stale memory.

---
 rtl/wb_buffer.sv | 140 ++++++++++++++
 tb/tb_wb_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// wb_buffer: write-back buffer sitting below the cache's dirty-eviction port.
// Victim entries {data, address} are queued in order and drained to main
// memory over a valid/ready handshake. Miss reads from the cache are snooped
// against the queue so that a read of a still-buffered line returns the
// newest buffered data.
//
// Ports:
//   CLK, Reset              clock, synchronous active-high reset
//   FIFO_we, FIFO_wd        push strobe / entry {data[63:32], addr[31:0]}
//   FIFO_full               buffer holds DEPTH entries
//   mw_Valid/Addr/Data      head entry presented to memory
//   mw_Ready                memory accepts the head this cycle
//   cm_ReadValid/ReadAddr   miss-read snoop request
//   snoop_hit, snoop_data   registered snoop result (one-cycle pulse)
//   count                   occupancy 0..DEPTH
//   overflow                sticky: push attempted while full
module wb_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             FIFO_we,
    input  logic [63:0]      FIFO_wd,
    output logic             FIFO_full,
    output logic             mw_Valid,
    output logic [31:0]      mw_Addr,
    output logic [31:0]      mw_Data,
    input  logic             mw_Ready,
    input  logic             cm_ReadValid,
    input  logic [31:0]      cm_ReadAddr,
    output logic             snoop_hit,
    output logic [31:0]      snoop_data,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             snoop_hit_q, snoop_hit_d;
    logic [31:0]      snoop_data_q, snoop_data_d;

    logic             full;
    logic             push;
    logic             pop;

    // Word-granular snoop: byte-offset bits of the read address do not matter.
    logic             unused_addr_lsbs;
    assign unused_addr_lsbs = ^cm_ReadAddr[1:0];

    always_comb begin
        full = (count_q == (PTR_W+1)'(DEPTH));
        push = FIFO_we & ~full;
        pop  = (count_q != '0) & mw_Ready;

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (FIFO_we & full);

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PTR_W+1)'(1);

        // Full/empty never coincide with a same-index push and pop, so the
        // order of these two updates does not matter.
        valid_d = valid_q;
        if (pop)
            valid_d[rd_ptr_q] = 1'b0;
        if (push)
            valid_d[wr_ptr_q] = 1'b1;
    end

    // Snoop walks the queue oldest-to-youngest so the last match wins; the
    // pre-pop contents are used, then an accepted push overrides as youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = rd_ptr_q;
        snoop_hit_d  = 1'b0;
        snoop_data_d = '0;
        if (cm_ReadValid) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if (valid_q[idx] && (addr_mem[idx][31:2] == cm_ReadAddr[31:2])) begin
                    snoop_hit_d  = 1'b1;
                    snoop_data_d = data_mem[idx];
                end
            end
            if (push && (FIFO_wd[31:2] == cm_ReadAddr[31:2])) begin
                snoop_hit_d  = 1'b1;
                snoop_data_d = FIFO_wd[63:32];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            snoop_hit_q  <= 1'b0;
            snoop_data_q <= '0;
        end else begin
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            snoop_hit_q  <= snoop_hit_d;
            snoop_data_q <= snoop_data_d;
        end
    end

    // Storage is qualified by valid/count, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= FIFO_wd[31:0];
            data_mem[wr_ptr_q] <= FIFO_wd[63:32];
        end
    end

    assign FIFO_full  = full;
    assign mw_Valid   = (count_q != '0);
    assign mw_Addr    = addr_mem[rd_ptr_q];
    assign mw_Data    = data_mem[rd_ptr_q];
    assign snoop_hit  = snoop_hit_q;
    assign snoop_data = snoop_data_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_buffer.sv
module tb_wb_buffer;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        FIFO_we;
    logic [63:0] FIFO_wd;
    logic        FIFO_full;
    logic        mw_Valid;
    logic [31:0] mw_Addr;
    logic [31:0] mw_Data;
    logic        mw_Ready;
    logic        cm_ReadValid;
    logic [31:0] cm_ReadAddr;
    logic        snoop_hit;
    logic [31:0] snoop_data;
    logic [3:0]  count;
    logic        overflow;

    wb_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .CLK(CLK), .Reset(Reset),
        .FIFO_we(FIFO_we), .FIFO_wd(FIFO_wd), .FIFO_full(FIFO_full),
        .mw_Valid(mw_Valid), .mw_Addr(mw_Addr), .mw_Data(mw_Data), .mw_Ready(mw_Ready),
        .cm_ReadValid(cm_ReadValid), .cm_ReadAddr(cm_ReadAddr),
        .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .count(count), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Reference model: an ordered queue of {data, addr} entries.
    logic [63:0] q[$];
    bit          m_ovf;
    bit          m_sh;
    logic [31:0] m_sd;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit we, input logic [63:0] wd, input bit rdy,
                              input bit rv, input logic [31:0] ra, input bit rst);
        bit full, push, pop;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_sh  = 0;
            m_sd  = '0;
            return;
        end
        full = (q.size() == DEPTH);
        push = we && !full;
        pop  = (q.size() != 0) && rdy;
        m_sh = 0;
        m_sd = '0;
        if (rv) begin
            foreach (q[i])
                if (q[i][31:2] == ra[31:2]) begin
                    m_sh = 1;
                    m_sd = q[i][63:32];
                end
            if (push && wd[31:2] == ra[31:2]) begin
                m_sh = 1;
                m_sd = wd[63:32];
            end
        end
        if (we && full) m_ovf = 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(wd);
    endtask

    task automatic compare_model();
        chk("full", 64'(FIFO_full), 64'(q.size() == DEPTH));
        chk("count", 64'(count), 64'(q.size()));
        chk("mw_valid", 64'(mw_Valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("mw_addr", 64'(mw_Addr), 64'(q[0][31:0]));
            chk("mw_data", 64'(mw_Data), 64'(q[0][63:32]));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("snoop_hit", 64'(snoop_hit), 64'(m_sh));
        chk("snoop_data", 64'(snoop_data), 64'(m_sd));
    endtask

    // One clock: drive at negedge, model advances at posedge, compare at next negedge.
    task automatic cyc(input bit we, input logic [63:0] wd, input bit rdy,
                       input bit rv, input logic [31:0] ra, input bit rst);
        FIFO_we      = we;
        FIFO_wd      = wd;
        mw_Ready     = rdy;
        cm_ReadValid = rv;
        cm_ReadAddr  = ra;
        Reset        = rst;
        @(posedge CLK);
        model_step(we, wd, rdy, rv, ra, rst);
        @(negedge CLK);
        compare_model();
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++)
            cyc(0, '0, 1, 0, '0, 0);
        chk("drained", 64'(count), 64'(0));
    endtask

    initial begin
        Reset = 1; FIFO_we = 0; FIFO_wd = '0; mw_Ready = 0;
        cm_ReadValid = 0; cm_ReadAddr = '0;
        @(negedge CLK);
        cyc(0, '0, 0, 0, '0, 1);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_valid", 64'(mw_Valid), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));

        // Single entry latency and pop
        cyc(1, {32'hDEADBEEF, 32'h0000_0104}, 0, 0, '0, 0);
        chk("t1_valid", 64'(mw_Valid), 64'(1));
        chk("t1_addr", 64'(mw_Addr), 64'h104);
        chk("t1_data", 64'(mw_Data), 64'hDEADBEEF);
        chk("t1_count", 64'(count), 64'(1));
        cyc(0, '0, 1, 0, '0, 0);
        chk("t1_pop_count", 64'(count), 64'(0));
        chk("t1_pop_valid", 64'(mw_Valid), 64'(0));

        // Fill, overflow, in-order drain
        for (int k = 0; k < 8; k++)
            cyc(1, {32'hA000_0000 + 32'(k), 32'(16 * k)}, 0, 0, '0, 0);
        chk("t2_full", 64'(FIFO_full), 64'(1));
        chk("t2_count", 64'(count), 64'(8));
        cyc(1, {32'hBAD0_0000, 32'h0000_0080}, 0, 0, '0, 0);
        chk("t2_ovf", 64'(overflow), 64'(1));
        chk("t2_count9", 64'(count), 64'(8));
        for (int k = 0; k < 8; k++) begin
            chk("t2_order", 64'(mw_Addr), 64'(16 * k));
            cyc(0, '0, 1, 0, '0, 0);
        end
        chk("t2_empty", 64'(mw_Valid), 64'(0));

        // Push and pop together while full: push rejected
        for (int k = 0; k < 8; k++)
            cyc(1, {32'hC000_0000 + 32'(k), 32'h300 + 32'(4 * k)}, 0, 0, '0, 0);
        cyc(1, {32'hC0FF_EE00, 32'h0000_0400}, 1, 0, '0, 0);
        chk("t3_count", 64'(count), 64'(7));
        chk("t3_ovf", 64'(overflow), 64'(1));
        drain();

        // Snoop youngest match
        cyc(1, {32'h11111111, 32'h200}, 0, 0, '0, 0);
        cyc(1, {32'h22222222, 32'h200}, 0, 0, '0, 0);
        cyc(0, '0, 0, 1, 32'h200, 0);
        chk("t4_hit", 64'(snoop_hit), 64'(1));
        chk("t4_data", 64'(snoop_data), 64'h22222222);
        cyc(0, '0, 0, 1, 32'h204, 0);
        chk("t4_miss_hit", 64'(snoop_hit), 64'(0));
        chk("t4_miss_data", 64'(snoop_data), 64'(0));
        cyc(0, '0, 0, 0, '0, 0);
        chk("t4_pulse", 64'(snoop_hit), 64'(0));
        drain();

        // Streaming through with pointer wrap
        for (int k = 0; k < 20; k++) begin
            cyc(1, {32'h5000_0000 + 32'(k), 32'h600 + 32'(4 * k)}, 1, 0, '0, 0);
            chk("t5_count_le1", 64'(count <= 1), 64'(1));
        end
        drain();

        // Reset mid-drain
        for (int k = 0; k < 3; k++)
            cyc(1, {32'h7000_0000 + 32'(k), 32'h700 + 32'(4 * k)}, 0, 0, '0, 0);
        cyc(0, '0, 1, 0, '0, 1);
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_valid", 64'(mw_Valid), 64'(0));
        chk("t6_ovf", 64'(overflow), 64'(0));
        for (int k = 0; k < 3; k++) begin
            cyc(0, '0, 1, 0, '0, 0);
            chk("t6_no_replay", 64'(mw_Valid), 64'(0));
        end

        // Randomized traffic over a small address pool so snoops hit often
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, ra;
            a  = 32'h100 + 32'(4 * $urandom_range(0, 7));
            ra = 32'h100 + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(0, 3));
            cyc(($urandom_range(0, 9) < 6), {$urandom(), a}, ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 2) == 0), ra, ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
